// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encodings
package uart_pkg;

    // Default bit period in clock cycles and data bits per frame.
    // The transmitter wrapper uses the same values so both ends agree.
    localparam int UART_D = 234;
    localparam int UART_L = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE  = ST_IDLE,
        RX_START = ST_START,
        RX_DATA  = ST_DATA,
        RX_STOP  = ST_STOP,
        RX_BREAK = ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input, resets to 1
//   i_clk  : destination clock
//   i_rst  : asynchronous active-high reset, forces both flops to 1 (idle line)
//   d      : asynchronous input
//   q      : synchronized output, two cycles behind d
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start bit, L data bits LSB first, one stop bit
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset
//   i_rxd   : serial line, asynchronous, idles high
//   i_ack   : consumer takes o_data this cycle
//   o_data  : last received byte, LSB is the first data bit
//   o_valid : o_data holds an unacknowledged byte
//   o_ferr  : one-cycle pulse when the stop bit is sampled low
//   o_ovr   : sticky overrun flag, cleared only by reset
//   o_busy  : frame reception in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int D = UART_D,
    parameter int L = UART_L
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rxd,
    input  logic         i_ack,
    output logic [L-1:0] o_data,
    output logic         o_valid,
    output logic         o_ferr,
    output logic         o_ovr,
    output logic         o_busy
);

    localparam int CW = $clog2(D);
    localparam int BW = $clog2(L + 1);

    // The counter is cleared on the edge that enters a state and then sees
    // value n-1 on the n-th following edge, hence the "- 1" on both limits.
    localparam logic [CW-1:0] HALF_LAST = CW'(D / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(D - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(L - 1);

    logic s_rxd;

    rx_state_e     state_q;
    rx_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] idx_q;
    logic [L-1:0]  sr_q;
    logic          done_q;

    logic cnt_clr;
    logic shift_en;
    logic frame_ok;
    logic frame_bad;

    uart_sync2 u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_rxd),
        .q     (s_rxd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!s_rxd) begin
                    state_d = RX_START;
                    cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = s_rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Leaving at mid stop bit lets the next start edge be caught
                // even with zero idle time between frames.
                if (cnt_q == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (s_rxd) begin
                        frame_ok = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // A line held low must go high before another frame can start.
                if (s_rxd) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            sr_q  <= '0;
        end else begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (state_q != RX_DATA) begin
                idx_q <= '0;
            end else if (shift_en) begin
                idx_q <= idx_q + BW'(1);
            end

            // Shift in at the MSB so the first data bit ends up in bit 0.
            if (shift_en) begin
                sr_q <= {s_rxd, sr_q[L-1:1]};
            end
        end
    end

    // sr_q is stable for a full bit period after the stop sample, so the
    // holding register can load it one cycle later via done_q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_q  <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ferr  <= 1'b0;
            o_ovr   <= 1'b0;
        end else begin
            done_q <= frame_ok;
            o_ferr <= frame_bad;
            if (done_q) begin
                o_data  <= sr_q;
                o_valid <= 1'b1;
                // An ack in the same cycle means the old byte was consumed.
                if (o_valid && !i_ack) begin
                    o_ovr <= 1'b1;
                end
            end else if (i_ack) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd, ack, rxd_lb, ack_lb;
    logic [7:0] data, data_lb;
    logic       valid, ferr, ovr, busy;
    logic       valid_lb, ferr_lb, ovr_lb, busy_lb;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ferr_cnt = 0;
    int ferr_lb_cnt = 0;
    int t_start  = 0;

    logic [7:0] q16[$];
    logic [7:0] qlb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ferr)    ferr_cnt    <= ferr_cnt + 1;
        if (ferr_lb) ferr_lb_cnt <= ferr_lb_cnt + 1;
    end

    uart_rx #(.D(16), .L(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd), .i_ack(ack),
        .o_data(data), .o_valid(valid), .o_ferr(ferr), .o_ovr(ovr), .o_busy(busy)
    );

    uart_rx #(.D(234), .L(8)) dut_lb (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd_lb), .i_ack(ack_lb),
        .o_data(data_lb), .o_valid(valid_lb), .o_ferr(ferr_lb), .o_ovr(ovr_lb), .o_busy(busy_lb)
    );

    task automatic drive_line(input bit lb, input logic v);
        if (lb) rxd_lb = v;
        else    rxd    = v;
    endtask

    // Must be called at a negedge; leaves the line high at the end of the stop bit.
    task automatic send_frame(input bit lb, input logic [7:0] b, input logic stop, input int d);
        t_start = cyc;
        drive_line(lb, 1'b0);
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_line(lb, b[i]);
            repeat (d) @(negedge clk);
        end
        drive_line(lb, stop);
        repeat (d) @(negedge clk);
        drive_line(lb, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!valid) $display("FAIL wait_valid: timeout after %0d cycles, o_valid=%b required 1", budget, valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; ack = 1'b0; rxd_lb = 1'b1; ack_lb = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h required 00", data); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", valid); else n_pass++;
        n_checks++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b required 0", ferr); else n_pass++;
        n_checks++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b required 0", ovr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int f0 = ferr_cnt;
        logic [7:0] exp;
        q16.push_back(8'h48);
        fork
            send_frame(1'b0, 8'h48, 1'b1, 16);
            begin
                wait_valid(400);
                n_checks++;
                if (cyc !== t_start + 156) $display("FAIL single_latency: o_valid at cycle %0d required %0d", cyc, t_start + 156);
                else n_pass++;
                exp = q16.pop_front();
                n_checks++; if (data !== exp) $display("FAIL single_data: got %h required %h", data, exp); else n_pass++;
            end
        join
        n_checks++; if (ferr_cnt !== f0) $display("FAIL single_ferr: %0d pulses required 0", ferr_cnt - f0); else n_pass++;
        n_checks++; if (ovr !== 1'b0) $display("FAIL single_ovr: got %b required 0", ovr); else n_pass++;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (valid !== 1'b0) $display("FAIL single_ack: o_valid %b required 0", valid); else n_pass++;
    endtask

    task automatic test_glitch();
        int f0 = ferr_cnt;
        int busy_n = 0;
        bit saw_valid = 0;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (valid) saw_valid = 1;
        end
        n_checks++;
        if (busy_n < 1 || busy_n > 8) $display("FAIL glitch_busy: busy for %0d cycles required 1..8", busy_n);
        else n_pass++;
        n_checks++; if (saw_valid !== 1'b0) $display("FAIL glitch_valid: o_valid seen %b required 0", saw_valid); else n_pass++;
        n_checks++; if (ferr_cnt !== f0) $display("FAIL glitch_ferr: %0d pulses required 0", ferr_cnt - f0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_idle: o_busy %b required 0", busy); else n_pass++;
    endtask

    task automatic test_framing_error();
        int f0 = ferr_cnt;
        bit saw_valid = 0;
        fork
            send_frame(1'b0, 8'h55, 1'b0, 16);
            begin
                repeat (160) begin
                    @(negedge clk);
                    if (valid) saw_valid = 1;
                end
            end
        join
        rxd = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) saw_valid = 1;
        end
        n_checks++; if (busy !== 1'b1) $display("FAIL ferr_busy_low: o_busy %b required 1", busy); else n_pass++;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL ferr_busy_release: o_busy %b required 0", busy); else n_pass++;
        n_checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse: %0d pulses required 1", ferr_cnt - f0); else n_pass++;
        n_checks++; if (saw_valid !== 1'b0) $display("FAIL ferr_valid: o_valid seen %b required 0", saw_valid); else n_pass++;
    endtask

    task automatic test_overrun(input bit ack_on_completion);
        int c0;
        logic [7:0] exp;
        q16.push_back(8'h12);
        q16.push_back(8'h34);
        fork
            begin
                send_frame(1'b0, 8'h12, 1'b1, 16);
                send_frame(1'b0, 8'h34, 1'b1, 16);
            end
            begin
                wait_valid(400);
                c0 = t_start;
                exp = q16.pop_front();
                n_checks++; if (data !== exp) $display("FAIL ovr_first_data: got %h required %h", data, exp); else n_pass++;
                if (ack_on_completion) begin
                    while (cyc < c0 + 160 + 155) @(negedge clk);
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                end else begin
                    while (cyc < c0 + 160 + 157) @(negedge clk);
                end
                exp = q16.pop_front();
                n_checks++; if (data !== exp) $display("FAIL ovr_second_data: got %h required %h", data, exp); else n_pass++;
                n_checks++; if (valid !== 1'b1) $display("FAIL ovr_valid: got %b required 1", valid); else n_pass++;
                n_checks++;
                if (ovr !== !ack_on_completion) $display("FAIL ovr_flag(ack=%0d): got %b required %b", ack_on_completion, ovr, !ack_on_completion);
                else n_pass++;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] part = 8'h3C;
        logic [7:0] exp;
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = part[i];
            repeat ((i == 3) ? 8 : 16) @(negedge clk);
        end
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: o_busy %b required 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (data !== 8'h00) $display("FAIL mid_rst_data: got %h required 00", data); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", valid); else n_pass++;
        n_checks++; if (ovr !== 1'b0) $display("FAIL mid_rst_ovr: got %b required 0", ovr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b required 0", busy); else n_pass++;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        q16.push_back(8'hA5);
        fork
            send_frame(1'b0, 8'hA5, 1'b1, 16);
            begin
                wait_valid(400);
                exp = q16.pop_front();
                n_checks++; if (data !== exp) $display("FAIL mid_clean_data: got %h required %h", data, exp); else n_pass++;
            end
        join
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_loopback();
        string msg = "Hello World\r\n";
        int f0 = ferr_lb_cnt;
        logic [7:0] exp;
        fork
            begin
                for (int i = 0; i < msg.len(); i++) begin
                    qlb.push_back(msg[i]);
                    send_frame(1'b1, msg[i], 1'b1, 234);
                end
            end
            begin
                for (int i = 0; i < msg.len(); i++) begin
                    int k = 0;
                    while (!valid_lb && k < 3000) begin
                        @(negedge clk);
                        k++;
                    end
                    exp = (qlb.size() > 0) ? qlb.pop_front() : 8'hxx;
                    n_checks++;
                    if (!valid_lb || data_lb !== exp)
                        $display("FAIL loopback_byte%0d: valid=%b data=%h required %h", i, valid_lb, data_lb, exp);
                    else n_pass++;
                    ack_lb = 1'b1;
                    @(negedge clk);
                    ack_lb = 1'b0;
                end
            end
        join
        repeat (300) @(negedge clk);
        n_checks++; if (ferr_lb_cnt !== f0) $display("FAIL loopback_ferr: %0d pulses required 0", ferr_lb_cnt - f0); else n_pass++;
        n_checks++; if (ovr_lb !== 1'b0) $display("FAIL loopback_ovr: got %b required 0", ovr_lb); else n_pass++;
        n_checks++; if (qlb.size() !== 0) $display("FAIL loopback_count: %0d bytes left required 0", qlb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_overrun(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_overrun(1'b1);
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
